switch_digit_display: RTL and testbench

SWITCH_DIGIT_DISPLAY -- requirements
Module: switch_digit_display

---
 rtl/switch_digit_display_pkg.sv | 21 ++
 rtl/switch_digit_display_sw_debounce.sv | 47 ++++
 rtl/switch_digit_display.sv | 112 +++++++++++
 tb/tb_switch_digit_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_digit_display_pkg.sv
// Shared segment constants, blink phase encoding and the bit-to-glyph helper
// for the switch/digit display block.
package switch_digit_display_pkg;

  localparam logic [7:0] SEG_ZERO  = 8'hC0;
  localparam logic [7:0] SEG_ONE   = 8'hF9;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    BLK_IDLE,
    BLK_OFF1,
    BLK_ON1,
    BLK_OFF2,
    BLK_ON2
  } blink_state_t;

  function automatic logic [7:0] seg_glyph(input logic bit_val);
    return bit_val ? SEG_ONE : SEG_ZERO;
  endfunction

endpackage

// File: rtl/switch_digit_display_sw_debounce.sv
// One switch channel: 2-flop synchronizer followed by a saturating stable-time
// debouncer. st_nxt exposes the state the debouncer will hold after this edge.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic sw,
  output logic st,
  output logic st_nxt,
  output logic chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sw_s;
  logic [CW-1:0] cnt;
  logic          flip;

  // The change is accepted on the cycle the counter is already at its ceiling,
  // so the counter can never wrap.
  assign flip   = (sw_s != st) && (cnt == CNT_MAX);
  assign st_nxt = st ^ flip;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync1 <= 1'b0;
      sw_s  <= 1'b0;
      st    <= 1'b0;
      cnt   <= '0;
      chg   <= 1'b0;
    end else begin
      sync1 <= sw;
      sw_s  <= sync1;
      st    <= st_nxt;
      chg   <= flip;
      if ((sw_s == st) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_digit_display.sv
// Debounced switches to LEDs and 0/1 seven-segment digits, with per-channel
// change pulses. Optional change-blink enabled by SWITCH_DIGIT_DISPLAY_BLINK_EN.
//
// Blink FSM (per digit, macro builds only):
//   state    | meaning
//   BLK_IDLE | steady glyph
//   BLK_OFF1 | first blank phase
//   BLK_ON1  | first glyph phase
//   BLK_OFF2 | second blank phase
//   BLK_ON2  | second glyph phase, then back to idle
module switch_digit_display
  import switch_digit_display_pkg::*;
#(
  parameter int NUM_CH          = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [NUM_CH-1:0]     SW,
  output logic [NUM_CH-1:0]     LEDR,
  output logic [8*NUM_CH-1:0]   HEX,
  output logic [NUM_CH-1:0]     CHG
);

  if (NUM_CH < 1 || NUM_CH > 6 || DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("switch_digit_display: illegal parameter value");
  end

`ifdef SWITCH_DIGIT_DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);
`endif

  logic [NUM_CH-1:0] st;
  logic [NUM_CH-1:0] st_nxt;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [7:0] hex_q;

    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_sys (CLOCK_50),
      .rst_b   (RESET_N),
      .sw      (SW[ch]),
      .st      (st[ch]),
      .st_nxt  (st_nxt[ch]),
      .chg     (CHG[ch])
    );

`ifdef SWITCH_DIGIT_DISPLAY_BLINK_EN
    blink_state_t     bst;
    blink_state_t     bst_nxt;
    logic [BLK_W-1:0] tmr;
    logic [BLK_W-1:0] tmr_nxt;
    logic             flip;
    logic             blank_nxt;

    // Blink is launched on the same edge the debounced state flips, so the
    // first blank phase lines up with the CHG pulse.
    assign flip = st_nxt[ch] ^ st[ch];

    always_comb begin
      bst_nxt = bst;
      tmr_nxt = tmr;
      if (flip) begin
        bst_nxt = BLK_OFF1;
        tmr_nxt = BLK_MAX;
      end else if (bst != BLK_IDLE) begin
        if (tmr == '0) begin
          tmr_nxt = BLK_MAX;
          case (bst)
            BLK_OFF1: bst_nxt = BLK_ON1;
            BLK_ON1:  bst_nxt = BLK_OFF2;
            BLK_OFF2: bst_nxt = BLK_ON2;
            default:  bst_nxt = BLK_IDLE;
          endcase
        end else begin
          tmr_nxt = tmr - BLK_W'(1);
        end
      end
      blank_nxt = (bst_nxt == BLK_OFF1) || (bst_nxt == BLK_OFF2);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        bst   <= BLK_IDLE;
        tmr   <= '0;
        hex_q <= SEG_ZERO;
      end else begin
        bst   <= bst_nxt;
        tmr   <= tmr_nxt;
        hex_q <= blank_nxt ? SEG_BLANK : seg_glyph(st_nxt[ch]);
      end
    end
`else
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        hex_q <= SEG_ZERO;
      end else begin
        hex_q <= seg_glyph(st_nxt[ch]);
      end
    end
`endif

    assign HEX[8*ch +: 8] = hex_q;
  end

  assign LEDR = st;

endmodule

// File: tb/tb_switch_digit_display.sv
// Randomized bench for switch_digit_display with a stable-time reference model
// and a CHG-event scoreboard.
module tb_switch_digit_display;

  localparam int NUM_CH = 6;
  localparam int DEB    = 4;
  localparam int BLK    = 3;
`ifdef SWITCH_DIGIT_DISPLAY_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [NUM_CH-1:0]   sw    = '0;
  logic [NUM_CH-1:0]   ledr;
  logic [8*NUM_CH-1:0] hex;
  logic [NUM_CH-1:0]   chg;

  switch_digit_display #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_CYCLES    (BLK)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .SW       (sw),
    .LEDR     (ledr),
    .HEX      (hex),
    .CHG      (chg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] mask;
  } evt_t;
  evt_t exp_q[$];

  // Reference model: input seen two edges late; a channel flips once that
  // delayed input has disagreed with the held state for DEB consecutive edges.
  int                cyc = 0;
  logic [NUM_CH-1:0] h1, h2, st_m, seen, fl;
  int                run [NUM_CH];
  int                last_flip [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (model cycle %0d, t=%0t)", name, act, req, cyc, $time);
    end
  endtask

  function automatic void model_reset();
    h1   = '0;
    h2   = '0;
    st_m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      run[i]       = 0;
      last_flip[i] = -1000;
    end
    exp_q.delete();
  endfunction

  function automatic logic [8*NUM_CH-1:0] exp_hex();
    logic [8*NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int  el;
      bit  blank;
      el    = cyc - last_flip[i];
      blank = BLINK_ON && el >= 0 && (el < BLK || (el >= 2*BLK && el < 3*BLK));
      r[8*i +: 8] = blank ? 8'hFF : (st_m[i] ? 8'hF9 : 8'hC0);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      seen = h2;
      h2   = h1;
      h1   = sw;
      fl   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (seen[i] != st_m[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            run[i]       = 0;
            st_m[i]      = ~st_m[i];
            fl[i]        = 1'b1;
            last_flip[i] = cyc;
          end
        end else begin
          run[i] = 0;
        end
      end
      if (fl != '0) exp_q.push_back('{cyc, fl});
    end
  end

  // Monitor: level outputs against the model every cycle, CHG pulses against
  // the scoreboard whenever one appears or one is overdue.
  always @(negedge clk) begin
    evt_t e;
    check("ledr", 64'(ledr), 64'(st_m));
    check("hex", 64'(hex), 64'(exp_hex()));
    if (chg != '0) begin
      if (exp_q.size() == 0) begin
        check("chg_unexpected", 64'(chg), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("chg_mask", 64'(chg), 64'(e.mask));
        check("chg_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("chg_missing", 64'(chg), 64'(e.mask));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  localparam logic [47:0] ALL_ZERO_GLYPH = {6{8'hC0}};

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check("rst_async_ledr", 64'(ledr), 64'(0));
    step(3);
    rst_n = 1'b1;
    step(4);
    check("idle_ledr", 64'(ledr), 64'(0));
    check("idle_hex", 64'(hex), 64'(ALL_ZERO_GLYPH));
    check("idle_chg", 64'(chg), 64'(0));

    // clean edge on channel 2
    sw[2] = 1'b1;
    step(5);
    check("ch2_early_ledr", 64'(ledr), 64'(0));
    step(1);
    check("ch2_ledr", 64'(ledr), 64'(6'b000100));
    check("ch2_chg", 64'(chg), 64'(6'b000100));
    check("ch2_hex", 64'(hex[23:16]), BLINK_ON ? 64'(8'hFF) : 64'(8'hF9));
    check("ch2_other_hex", 64'({hex[47:24], hex[15:0]}), 64'({5{8'hC0}}));
    step(1);
    check("ch2_chg_one_cycle", 64'(chg), 64'(0));

    // short bounce on channel 0
    sw[0] = 1'b1;
    step(3);
    sw[0] = 1'b0;
    step(10);
    check("bounce_ledr", 64'(ledr), 64'(6'b000100));
    check("bounce_hex", 64'(hex), 64'(48'hC0C0C0F9C0C0));

    // all channels together
    sw = '0;
    step(8);
    check("all_pre_ledr", 64'(ledr), 64'(0));
    sw = 6'h3F;
    step(5);
    check("all_early_ledr", 64'(ledr), 64'(0));
    step(1);
    check("all_ledr", 64'(ledr), 64'(6'h3F));
    check("all_chg", 64'(chg), 64'(6'h3F));
    step(1);
    check("all_chg_one_cycle", 64'(chg), 64'(0));

    // reset in the middle of a count on channel 1
    sw = '0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    sw = 6'b000010;
    step(5);
    rst_n = 1'b0;
    #1;
    check("midrst_ledr", 64'(ledr), 64'(0));
    check("midrst_chg", 64'(chg), 64'(0));
    check("midrst_hex", 64'(hex), 64'(ALL_ZERO_GLYPH));
    step(2);
    rst_n = 1'b1;
    step(5);
    check("midrst_early_ledr", 64'(ledr), 64'(0));
    step(1);
    check("midrst_ledr_after", 64'(ledr), 64'(6'b000010));
    check("midrst_chg_after", 64'(chg), 64'(6'b000010));

    // randomized bouncing with occasional resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) sw = 6'($urandom);
      else sw[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      step($urandom_range(1, 7));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    step(16);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
